// File: rtl/sha256_block_sequencer_if.sv
// Message-word stream and digest handshake between the source/consumer and sha256_block_sequencer.
interface sha256_block_sequencer_if;
    logic         word_valid;
    logic         word_ready;
    logic [31:0]  word_data;
    logic         word_first;
    logic         digest_valid;
    logic         digest_ready;
    logic [255:0] digest;

    modport master (
        output word_valid, word_data, word_first, digest_ready,
        input  word_ready, digest_valid, digest
    );

    modport slave (
        input  word_valid, word_data, word_first, digest_ready,
        output word_ready, digest_valid, digest
    );
endinterface

// File: rtl/sha256_block_sequencer.sv
// Buffers one 16-word block, steps the SHA-256 round generator, folds its final state into the chaining digest.
// Define SHA256_SEQ_SHA224_EN to add input sel_224 (SHA-224 IV selected with a first-block W0).
module sha256_block_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef SHA256_SEQ_SHA224_EN
    input  logic                    sel_224,
`endif
    sha256_block_sequencer_if.slave bus,
    output logic [5:0]              gen_counter,
    output logic [31:0]             gen_word,
    output logic [255:0]            gen_init,
    input  logic [287:0]            gen_state,
    output logic                    busy
);
    localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [7:0]   DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, FINAL, OUT} state_e;

    state_e       state_q;
    logic [3:0]   cnt_q;
    logic [7:0]   drain_q;
    logic [5:0]   gen_counter_q;
    logic         word_ready_q;
    logic         digest_valid_q;
    logic         busy_q;
    logic [255:0] chain_q;
    logic [255:0] digest_q;
    logic [31:0]  buf_q [16];
    logic [255:0] sum_d;
    logic [255:0] iv_d;
    logic         word_hs;

`ifdef SHA256_SEQ_SHA224_EN
    localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    assign iv_d = sel_224 ? IV224 : IV256;
`else
    assign iv_d = IV256;
`endif

    assign word_hs = bus.word_valid & word_ready_q;

    // Working A arrives split in two halves; each 32-bit word is added independently.
    always_comb begin
        sum_d = '0;
        sum_d[255:224] = chain_q[255:224] + gen_state[287:256] + gen_state[255:224];
        for (int unsigned i = 0; i < 7; i++) begin
            sum_d[i*32 +: 32] = chain_q[i*32 +: 32] + gen_state[i*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            drain_q        <= '0;
            gen_counter_q  <= '0;
            word_ready_q   <= 1'b0;
            digest_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            chain_q        <= IV256;
            digest_q       <= IV256;
        end else begin
            case (state_q)
                IDLE: begin
                    word_ready_q <= 1'b1;
                    if (word_hs) begin
                        buf_q[0] <= bus.word_data;
                        chain_q  <= bus.word_first ? iv_d : digest_q;
                        cnt_q    <= 4'd1;
                        busy_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (word_hs) begin
                        buf_q[cnt_q] <= bus.word_data;
                        cnt_q        <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            word_ready_q  <= 1'b0;
                            gen_counter_q <= '0;
                            state_q       <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (gen_counter_q == 6'd63) begin
                        drain_q <= '0;
                        state_q <= DRAIN;
                    end else begin
                        gen_counter_q <= gen_counter_q + 6'd1;
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        gen_counter_q <= '0;
                        state_q       <= FINAL;
                    end else begin
                        drain_q <= drain_q + 8'd1;
                    end
                end
                FINAL: begin
                    chain_q        <= sum_d;
                    digest_q       <= sum_d;
                    digest_valid_q <= 1'b1;
                    state_q        <= OUT;
                end
                OUT: begin
                    if (bus.digest_ready) begin
                        digest_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        word_ready_q   <= 1'b1;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.word_ready   = word_ready_q;
    assign bus.digest_valid = digest_valid_q;
    assign bus.digest       = digest_q;
    assign gen_counter      = gen_counter_q;
    assign gen_init         = chain_q;
    assign busy             = busy_q;
    assign gen_word         = (state_q == RUN && gen_counter_q < 6'd16) ? buf_q[gen_counter_q[3:0]] : '0;
endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Bench for sha256_block_sequencer: behavioural 3-stage round generator plus a plain SHA-256 compression reference.
module tb_sha256_block_sequencer;
    localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_448 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_448A = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_448B = {480'h0, 32'h000001c0};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sel224 = 1'b0;
    logic [5:0]   gen_counter;
    logic [31:0]  gen_word;
    logic [255:0] gen_init;
    logic [287:0] gen_state;
    logic         busy;
    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [31:0]  blk [16];
    logic [255:0] tb_chain = IV256;

    sha256_block_sequencer_if bus();

    sha256_block_sequencer #(.DRAIN_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SHA256_SEQ_SHA224_EN
        .sel_224     (sel224),
`endif
        .bus         (bus),
        .gen_counter (gen_counter),
        .gen_word    (gen_word),
        .gen_init    (gen_init),
        .gen_state   (gen_state),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [31:0] m [16]);
        logic [31:0]  w [64];
        logic [255:0] s;
        logic [255:0] r;
        s = h;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
            s = sha_round(s, w[t], K[t]);
        end
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = h[i*32 +: 32] + s[i*32 +: 32];
        return r;
    endfunction

    // Generator model: counter/word pass two delay registers, then one round is applied per new counter value.
    logic [5:0]   ga_cnt = '0, gb_cnt = '0, g_last = '0;
    logic [31:0]  ga_w = '0, gb_w = '0, g_split = '0;
    logic [31:0]  gw [64];
    logic [255:0] g_st = '0;

    function automatic logic [31:0] gen_sched(input logic [5:0] t, input logic [31:0] w);
        if (t < 6'd16) return w;
        return ssig1(gw[t - 6'd2]) + gw[t - 6'd7] + ssig0(gw[t - 6'd15]) + gw[t - 6'd16];
    endfunction

    always @(posedge clk) begin
        ga_cnt <= gen_counter;
        ga_w   <= gen_word;
        gb_cnt <= ga_cnt;
        gb_w   <= ga_w;
        if (gb_cnt == 6'd0 || gb_cnt != g_last) begin
            gw[gb_cnt] <= gen_sched(gb_cnt, gb_w);
            g_st       <= sha_round((gb_cnt == 6'd0) ? gen_init : g_st, gen_sched(gb_cnt, gb_w), K[gb_cnt]);
            g_last     <= gb_cnt;
            g_split    <= $urandom;
        end
    end
    assign gen_state = {g_st[255:224] - g_split, g_split, g_st[223:0]};

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_blk(input logic [511:0] v);
        for (int i = 0; i < 16; i++) blk[i] = v[511 - 32*i -: 32];
    endtask

    task automatic send_word(input logic [31:0] d, input logic f, input logic stall);
        int unsigned n;
        if (stall) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
                bus.word_valid = 1'b0;
                bus.word_data  = $urandom;
                @(negedge clk);
            end
        end
        bus.word_valid = 1'b1;
        bus.word_data  = d;
        bus.word_first = f;
        n = 0;
        while (!bus.word_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("word_ready", 288'(bus.word_ready), 288'(1'b1));
        @(negedge clk);
        bus.word_valid = 1'b0;
        bus.word_first = 1'($urandom);
    endtask

    task automatic send_blk(input logic f, input logic stall);
        for (int i = 0; i < 16; i++) send_word(blk[i], (i == 0) ? f : 1'($urandom), stall);
    endtask

    task automatic wait_digest();
        int unsigned lat;
        logic [5:0]  ec;
        logic [31:0] ew;
        lat = 0;
        while (!bus.digest_valid && lat < 200) begin
            ec = (lat < 64) ? lat[5:0] : ((lat < 66) ? 6'd63 : 6'd0);
            ew = (lat < 16) ? blk[lat[3:0]] : 32'd0;
            check("run_cycle", 288'({gen_counter, gen_word, bus.word_ready, busy}), 288'({ec, ew, 1'b0, 1'b1}));
            @(negedge clk);
            lat++;
        end
        check("latency", 288'(lat), 288'(67));
    endtask

    task automatic take_digest(input logic [255:0] exp, input int unsigned hold);
        check("digest", 288'({bus.digest_valid, bus.digest}), 288'({1'b1, exp}));
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge clk);
            check("out_hold", 288'({bus.digest_valid, bus.word_ready, busy, bus.digest}), 288'({3'b101, exp}));
        end
        bus.digest_ready = 1'b1;
        @(negedge clk);
        bus.digest_ready = 1'b0;
        check("after_take", 288'({bus.digest_valid, bus.word_ready, busy, bus.digest}), 288'({3'b010, exp}));
    endtask

    task automatic run_block(input logic f, input logic stall, input int unsigned hold);
        logic [255:0] exp;
        if (f) tb_chain = sel224 ? IV224 : IV256;
        exp = compress(tb_chain, blk);
        send_blk(f, stall);
        check("gen_init", 288'(gen_init), 288'(tb_chain));
        wait_digest();
        take_digest(exp, hold);
        tb_chain = exp;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int unsigned n;
        bus.word_valid   = 1'b0;
        bus.word_data    = '0;
        bus.word_first   = 1'b0;
        bus.digest_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", 288'({busy, bus.digest_valid, bus.word_ready, gen_counter, gen_word}), 288'(0));
        check("reset_digest", 288'({bus.digest, gen_init}), 288'({IV256, IV256}));
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 288'({bus.word_ready, busy}), 288'(2'b10));

        set_blk(B_ABC);
        run_block(1'b1, 1'b0, 0);
        check("kat_abc", 288'(bus.digest), 288'(D_ABC));

        set_blk(B_EMPTY);
        run_block(1'b1, 1'b0, 0);
        check("kat_empty", 288'(bus.digest), 288'(D_EMPTY));

        set_blk(B_448A);
        run_block(1'b1, 1'b0, 0);
        set_blk(B_448B);
        run_block(1'b0, 1'b0, 0);
        check("kat_448", 288'(bus.digest), 288'(D_448));

        set_blk(B_ABC);
        run_block(1'b1, 1'b0, 0);
        check("kat_abc_restart", 288'(bus.digest), 288'(D_ABC));

        set_blk(B_ABC);
        run_block(1'b1, 1'b1, 20);
        check("kat_abc_stall", 288'(bus.digest), 288'(D_ABC));

        // Abort mid-block: no digest, then a clean block afterwards.
        set_blk(B_EMPTY);
        send_blk(1'b1, 1'b0);
        n = 0;
        while (gen_counter != 6'd30 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_30", 288'(gen_counter), 288'(30));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort", 288'({busy, bus.digest_valid, bus.word_ready, gen_counter, bus.digest}), 288'({9'b0, IV256}));
        tb_chain = IV256;
        set_blk(B_ABC);
        run_block(1'b1, 1'b0, 0);
        check("kat_abc_after_rst", 288'(bus.digest), 288'(D_ABC));

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            run_block((r == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5));
        end

`ifdef SHA256_SEQ_SHA224_EN
        sel224 = 1'b1;
        set_blk(B_ABC);
        run_block(1'b1, 1'b0, 0);
        check("kat_sha224", 288'(bus.digest[255:32]),
              288'(224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7));
        sel224 = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
